// File: rtl/ixc_gfifo_pkg.sv
// Shared types and helpers for the multi-channel GFIFO port.
// Default widths, entry layout and round-robin pointer step.
package ixc_gfifo_pkg;

  localparam int unsigned NCH_D  = 4;
  localparam int unsigned DW_D   = 64;
  localparam int unsigned CBW_D  = 20;
  localparam int unsigned LENW_D = 12;
  localparam int unsigned LBD_D  = 4;
  localparam int unsigned GFW_D  = 512;

  typedef struct packed {
    logic [CBW_D-1:0]  cbid;
    logic [LENW_D-1:0] len;
    logic [DW_D-1:0]   data;
  } entry_t;

  // Channel after w, wrapping n-1 -> 0.
  function automatic int unsigned rr_next(
    input int unsigned w,
    input int unsigned n
  );
    return (w + 1 >= n) ? 0 : w + 1;
  endfunction

endpackage

// File: rtl/ixc_gfifo_lb.sv
// Single-channel circular local buffer, LBD entries of EW bits.
// Ports: clk_i, rst_i (sync, high), push_i, pop_i, wdata_i, rdata_o, full_o, empty_o.
module ixc_gfifo_lb
  import ixc_gfifo_pkg::*;
#(
  parameter int unsigned EW  = 96,
  parameter int unsigned LBD = LBD_D
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [EW-1:0] wdata_i,
  output logic [EW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(LBD);

  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic [EW-1:0] mem_q [LBD];
  logic          do_push, do_pop;

  // Extra pointer MSB separates full from empty.
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ixc_gfifo_port_mc.sv
// Multi-channel GFIFO port: toggle-request capture, per-channel buffers,
// round-robin issue to the global FIFO, token chaining, overflow count.
module ixc_gfifo_port_mc
  import ixc_gfifo_pkg::*;
#(
  parameter int unsigned NCH  = NCH_D,
  parameter int unsigned DW   = DW_D,
  parameter int unsigned CBW  = CBW_D,
  parameter int unsigned LENW = LENW_D,
  parameter int unsigned LBD  = LBD_D,
  parameter int unsigned GFW  = GFW_D
) (
  input  logic                 fclk,
  input  logic                 rst,
  input  logic [NCH-1:0]       ireq,
  input  logic [NCH*CBW-1:0]   cbid,
  input  logic [NCH*LENW-1:0]  len,
  input  logic [NCH*DW-1:0]    idata,
  input  logic                 lock,
  input  logic                 tkin,
  input  logic                 rtkin,
  output logic                 tkout,
  output logic                 gf_req,
  output logic [(NCH>1 ? $clog2(NCH) : 1)-1:0] gf_ch,
  output logic [CBW-1:0]       gf_cbid,
  output logic [LENW-1:0]      gf_len,
  output logic [GFW-1:0]       gf_data,
  input  logic                 gf_full,
  output logic [NCH-1:0]       lb_full,
  output logic [15:0]          ovf_cnt
);

  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned EW  = CBW + LENW + DW;

  typedef struct packed {
    logic [CBW-1:0]  cbid;
    logic [LENW-1:0] len;
    logic [DW-1:0]   data;
  } ent_t;

  logic [NCH-1:0] ireqr_q, ireqr_d;
  logic [NCH-1:0] pend, push, pop, blk;
  logic [NCH-1:0] full, empty, nonempty;
  ent_t           rdata [NCH];
  ent_t           wr_ent [NCH];
  ent_t           win_ent;

  logic [CHW-1:0]  rr_q, rr_d;
  logic [CHW-1:0]  win;
  logic            go;
  logic            req_q, req_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [CBW-1:0]  cb_q, cb_d;
  logic [LENW-1:0] ln_q, ln_d;
  logic [GFW-1:0]  dt_q, dt_d;
  logic [15:0]     ovf_q, ovf_d;
  logic [16:0]     blk_n, ovf_sum;

  assign pend     = ireq ^ ireqr_q;
  assign nonempty = ~empty;
  // Full is the registered state: a same-cycle pop never frees a slot.
  assign push     = pend & ~full & {NCH{~lock}};
  assign blk      = pend & full & {NCH{~lock}};

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign wr_ent[c].cbid = cbid[c*CBW +: CBW];
    assign wr_ent[c].len  = len[c*LENW +: LENW];
    assign wr_ent[c].data = idata[c*DW +: DW];

    ixc_gfifo_lb #(.EW(EW), .LBD(LBD)) u_lb (
      .clk_i   (fclk),
      .rst_i   (rst),
      .push_i  (push[c]),
      .pop_i   (pop[c]),
      .wdata_i (wr_ent[c]),
      .rdata_o (rdata[c]),
      .full_o  (full[c]),
      .empty_o (empty[c])
    );
  end

  assign go = (|nonempty) & ~lock & ~tkin & ~rtkin & ~gf_full;

  // First non-empty channel scanning upward from rr, with wrap.
  always_comb begin
    logic hit;
    hit = 1'b0;
    win = '0;
    for (int i = 0; i < NCH; i++) begin
      int idx;
      idx = int'(rr_q) + i;
      if (idx >= int'(NCH)) idx = idx - int'(NCH);
      if (!hit && nonempty[idx]) begin
        hit = 1'b1;
        win = CHW'(idx);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (go) pop[win] = 1'b1;
  end

  assign win_ent = rdata[win];

  always_comb begin
    ireqr_d = ireqr_q;
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) ireqr_d[c] = ireq[c];
    end
  end

  always_comb begin
    req_d = go;
    rr_d  = rr_q;
    ch_d  = ch_q;
    cb_d  = cb_q;
    ln_d  = ln_q;
    dt_d  = dt_q;
    if (go) begin
      rr_d = CHW'(rr_next(32'(win), NCH));
      ch_d = win;
      cb_d = win_ent.cbid;
      ln_d = win_ent.len;
      dt_d = '0;
      dt_d[DW-1:0] = win_ent.data;
    end
  end

  // One count per blocked channel per cycle, saturating.
  always_comb begin
    blk_n = '0;
    for (int c = 0; c < NCH; c++) begin
      blk_n = blk_n + 17'(blk[c]);
    end
    ovf_sum = {1'b0, ovf_q} + blk_n;
    ovf_d   = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      ireqr_q <= '0;
      rr_q    <= '0;
      req_q   <= 1'b0;
      ch_q    <= '0;
      cb_q    <= '0;
      ln_q    <= '0;
      dt_q    <= '0;
      ovf_q   <= '0;
    end else begin
      ireqr_q <= ireqr_d;
      rr_q    <= rr_d;
      req_q   <= req_d;
      ch_q    <= ch_d;
      cb_q    <= cb_d;
      ln_q    <= ln_d;
      dt_q    <= dt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tkout   = tkin | (|nonempty);
  assign gf_req  = req_q;
  assign gf_ch   = ch_q;
  assign gf_cbid = cb_q;
  assign gf_len  = ln_q;
  assign gf_data = dt_q;
  assign lb_full = full;
  assign ovf_cnt = ovf_q;

endmodule
